lfsr_tick_gen: RTL and testbench

//  Parametrised LFSR-based periodic tick generator. One maximal-length XNOR LFSR
//  (WIDTH 3..32) counts from the all-zeros seed up to a run-time terminal pattern,

---
 rtl/lfsr_tick_gen.sv | 148 ++++++++++++++
 tb/tb_lfsr_tick_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_tick_gen.sv
// lfsr_tick_gen: programmable-period tick generator built on a maximal-length
// XNOR LFSR. The LFSR runs from the all-zeros seed up to a run-time terminal
// pattern, emits a one-cycle tick and reloads. A small binary counter turns
// the tick stream into NUM_CH divided pulse outputs (tick / 2^(k+1)).
// Optional macro LFSR_TICK_STATE_OUT_EN exposes the LFSR state on o_Lfsr.
module lfsr_tick_gen #(
    parameter int WIDTH  = 24,
    parameter int NUM_CH = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Enable,
    input  logic              i_Clear,
    input  logic [WIDTH-1:0]  i_Term,
    output logic              o_Tick,
    output logic [NUM_CH-1:0] o_Tick_Div
`ifdef LFSR_TICK_STATE_OUT_EN
    ,
    output logic [WIDTH-1:0]  o_Lfsr
`endif
);

    // Bit mask for one tap; tap n feeds from LFSR bit n-1.
    function automatic logic [31:0] tapBit(input int n);
        return 32'h1 << (n - 1);
    endfunction

    // Maximal-length XNOR tap sets (XAPP052) for widths 3..32.
    function automatic logic [31:0] tapMask(input int w);
        logic [31:0] m;
        case (w)
            3:       m = tapBit(3)  | tapBit(2);
            4:       m = tapBit(4)  | tapBit(3);
            5:       m = tapBit(5)  | tapBit(3);
            6:       m = tapBit(6)  | tapBit(5);
            7:       m = tapBit(7)  | tapBit(6);
            8:       m = tapBit(8)  | tapBit(6)  | tapBit(5)  | tapBit(4);
            9:       m = tapBit(9)  | tapBit(5);
            10:      m = tapBit(10) | tapBit(7);
            11:      m = tapBit(11) | tapBit(9);
            12:      m = tapBit(12) | tapBit(6)  | tapBit(4)  | tapBit(1);
            13:      m = tapBit(13) | tapBit(4)  | tapBit(3)  | tapBit(1);
            14:      m = tapBit(14) | tapBit(5)  | tapBit(3)  | tapBit(1);
            15:      m = tapBit(15) | tapBit(14);
            16:      m = tapBit(16) | tapBit(15) | tapBit(13) | tapBit(4);
            17:      m = tapBit(17) | tapBit(14);
            18:      m = tapBit(18) | tapBit(11);
            19:      m = tapBit(19) | tapBit(6)  | tapBit(2)  | tapBit(1);
            20:      m = tapBit(20) | tapBit(17);
            21:      m = tapBit(21) | tapBit(19);
            22:      m = tapBit(22) | tapBit(21);
            23:      m = tapBit(23) | tapBit(18);
            24:      m = tapBit(24) | tapBit(23) | tapBit(22) | tapBit(17);
            25:      m = tapBit(25) | tapBit(22);
            26:      m = tapBit(26) | tapBit(6)  | tapBit(2)  | tapBit(1);
            27:      m = tapBit(27) | tapBit(5)  | tapBit(2)  | tapBit(1);
            28:      m = tapBit(28) | tapBit(25);
            29:      m = tapBit(29) | tapBit(27);
            30:      m = tapBit(30) | tapBit(6)  | tapBit(4)  | tapBit(1);
            31:      m = tapBit(31) | tapBit(28);
            32:      m = tapBit(32) | tapBit(22) | tapBit(2)  | tapBit(1);
            default: m = 32'h0;
        endcase
        return m;
    endfunction

    localparam logic [31:0] TAP_MASK = tapMask(WIDTH);

    // Reject unsupported configurations at elaboration time.
    generate
        if (WIDTH < 3 || WIDTH > 32) begin : gBadWidth
            $error("lfsr_tick_gen: WIDTH must be in 3..32");
        end
        if (NUM_CH < 1 || NUM_CH > 16) begin : gBadNumCh
            $error("lfsr_tick_gen: NUM_CH must be in 1..16");
        end
    endgenerate

    logic [WIDTH-1:0]  lfsr_q, lfsr_d;
    logic [NUM_CH-1:0] cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [NUM_CH-1:0] tickDiv_q, tickDiv_d;

    logic              feedback;
    logic              match;
    logic [WIDTH-1:0]  lfsrShift;
    logic [NUM_CH-1:0] cntInc;
    logic [NUM_CH-1:0] divHit;
    logic [NUM_CH-1:0] lowMask;

    assign feedback  = ~^(lfsr_q & TAP_MASK[WIDTH-1:0]);
    assign lfsrShift = {lfsr_q[WIDTH-2:0], feedback};
    assign match     = (lfsr_q == i_Term);
    assign cntInc    = cnt_q + 1'b1;

    // Channel k fires when the low k+1 bits of the incremented counter wrap to zero.
    always_comb begin
        lowMask = '0;
        divHit  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            lowMask[k] = 1'b1;
            divHit[k]  = ((cntInc & lowMask) == '0);
        end
    end

    // Next-state selection with priority clear > enable > hold.
    always_comb begin
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        tickDiv_d = '0;
        if (i_Clear) begin
            lfsr_d = '0;
            cnt_d  = '0;
        end else if (i_Enable) begin
            if (match) begin
                lfsr_d    = '0;
                cnt_d     = cntInc;
                tick_d    = 1'b1;
                tickDiv_d = divHit;
            end else begin
                lfsr_d = lfsrShift;
            end
        end
    end

    // State and output registers; synchronous active-low reset overrides everything.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            lfsr_q    <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            tickDiv_q <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            tickDiv_q <= tickDiv_d;
        end
    end

    assign o_Tick     = tick_q;
    assign o_Tick_Div = tickDiv_q;
`ifdef LFSR_TICK_STATE_OUT_EN
    assign o_Lfsr     = lfsr_q;
`endif

endmodule

// File: tb/tb_lfsr_tick_gen.sv
// tb_lfsr_tick_gen: directed bench for lfsr_tick_gen at WIDTH=4, NUM_CH=2.
// LFSR sequence from 0 for taps 4,3: 0,1,3,7,E,D,B,6,C,9,2,5,A,4,8.
module tb_lfsr_tick_gen;

    localparam int W  = 4;
    localparam int NC = 2;

    logic          clk = 1'b0;
    logic          rstL;
    logic          clear;
    logic          enable;
    logic [W-1:0]  term;
    logic          tick;
    logic [NC-1:0] tickDiv;
`ifdef LFSR_TICK_STATE_OUT_EN
    logic [W-1:0]  lfsr;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          rstL;
        logic          clear;
        logic          enable;
        logic [W-1:0]  term;
        logic          expTick;
        logic [NC-1:0] expDiv;
    } vec_t;

    vec_t vecs[25];

    lfsr_tick_gen #(.WIDTH(W), .NUM_CH(NC)) dut (
        .i_Clk      (clk),
        .i_Rst_L    (rstL),
        .i_Enable   (enable),
        .i_Clear    (clear),
        .i_Term     (term),
        .o_Tick     (tick),
        .o_Tick_Div (tickDiv)
`ifdef LFSR_TICK_STATE_OUT_EN
        ,
        .o_Lfsr     (lfsr)
`endif
    );

    always #5 clk = ~clk;

    // Drive one set of inputs, clock it in, and settle just after the edge.
    task automatic applyStimulus(input logic r, input logic c, input logic e, input logic [W-1:0] t);
        rstL   = r;
        clear  = c;
        enable = e;
        term   = t;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Run enabled cycles until a tick appears; -1 if none within the budget.
    task automatic cyclesToTick(input logic [W-1:0] t, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, t);
            if (tick) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int tickCount;

        rstL = 1'b0; clear = 1'b0; enable = 1'b1; term = 4'h7;

        //             rstL  clr   en    term   tick  div
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 2'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 2'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 2'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b1, 2'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 2'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 2'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 2'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b1, 2'd1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 2'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 2'd1};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 2'd0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 2'd3};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 2'd0};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 2'd1};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 2'd0};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 2'd3};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0};
        vecs[22] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 2'd0};
        vecs[23] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0};
        vecs[24] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 2'd0};

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i].rstL, vecs[i].clear, vecs[i].enable, vecs[i].term);
            checkOutput($sformatf("vec%0d_tick", i), int'(tick), int'(vecs[i].expTick));
            checkOutput($sformatf("vec%0d_div", i), int'(tickDiv), int'(vecs[i].expDiv));
`ifdef LFSR_TICK_STATE_OUT_EN
            if (!vecs[i].rstL) checkOutput($sformatf("vec%0d_lfsr_reset", i), int'(lfsr), 0);
`endif
        end

        // Enable dropped at LFSR=3 for 5 cycles, then resumed.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h7);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h7);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h7);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'h7);
            checkOutput($sformatf("hold%0d_tick", i), int'(tick), 0);
`ifdef LFSR_TICK_STATE_OUT_EN
            checkOutput($sformatf("hold%0d_lfsr", i), int'(lfsr), 3);
`endif
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h7);
        checkOutput("resume1_tick", int'(tick), 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h7);
        checkOutput("resume2_tick", int'(tick), 1);

        // Clear in the match cycle: no tick, and the divider counter restarts at 0.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h7);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h7);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h7);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h7);
        checkOutput("clrmatch_tick", int'(tick), 0);
`ifdef LFSR_TICK_STATE_OUT_EN
        checkOutput("clrmatch_lfsr", int'(lfsr), 0);
`endif
        cyclesToTick(4'h7, 10, n);
        checkOutput("clr_first_period", n, 4);
        checkOutput("clr_first_div", int'(tickDiv), 0);
        cyclesToTick(4'h7, 10, n);
        checkOutput("clr_second_period", n, 4);
        checkOutput("clr_second_div", int'(tickDiv), 1);

        // Reset while the LFSR sits on the match pattern.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h7);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h7);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h7);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h7);
        checkOutput("rstmatch_tick", int'(tick), 0);
        checkOutput("rstmatch_div", int'(tickDiv), 0);
        cyclesToTick(4'h7, 10, n);
        checkOutput("rst_restart_period", n, 4);

        // Term 8 is the last state of the sequence: period of 15 enabled cycles.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h8);
        cyclesToTick(4'h8, 40, n);
        checkOutput("term8_first_period", n, 15);
        cyclesToTick(4'h8, 40, n);
        checkOutput("term8_second_period", n, 15);

        // Term F is the lock-up state and is never reached.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hF);
        tickCount = 0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 4'hF);
            if (tick) tickCount++;
        end
        checkOutput("termF_ticks", tickCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
